periph_bus_ctrl: RTL and testbench
==================================

// Module: periph_bus_ctrl
// PURPOSE
//  Parametrised, clocked peripheral bus controller between the MIPS data port and up to 16 peripherals.
//  Decodes address[31] (peripheral path), [11:8] (slot) and [7:4] (register), and drives one-hot ce/rw strobes.
//  Adds per-slot ready handshake, CPU stall, access timeout, bus error and per-slot read-width masking.
//  Sits between the core's memory stage and the peripheral slots; the data memory path (address[31]=0) is untouched.
// PARAMETERS
//  NUM_PERIPH      4        number of slots, 1..16; slot index >= NUM_PERIPH is unmapped
//  NARROW_MASK     16'h0004 bit i=1: reads from slot i return {24'b0, rdata[7:0]}
//  WO_MASK         16'h0008 bit i=1: slot i is write-only; reads complete without a peripheral strobe
//  TIMEOUT         255      ACCESS cycles before abort; 0 disables timeout
// PORTS
//  clk              in   1               single clock, all state on rising edge
//  rst              in   1               synchronous, active-high reset
//  address          in   32              CPU address
//  rw               in   1               1=write, 0=read
//  ce               in   1               CPU access enable
//  data_from_mips   in   32              CPU write data
//  data_from_periph in   32*NUM_PERIPH   slot i read data at [32*i+31:32*i]
//  periph_ready     in   NUM_PERIPH      slot i completes the current access
//  ce_out           out  NUM_PERIPH      one-hot slot enable
//  rw_out           out  NUM_PERIPH      one-hot slot write strobe (subset of ce_out)
//  data_to_periph   out  32              latched write data; 0 during reads/idle
//  address_reg      out  4               latched register index (address[7:4])
//  data_to_mips     out  32              read data, valid only in DONE; else 0
//  stall            out  1               hold the CPU pipeline
//  bus_error        out  1               one-cycle pulse on unmapped slot or timeout
// BEHAVIOUR
//  - Reset: state IDLE, every output 0, timeout counter 0. rst at any cycle aborts the access; no strobe the next cycle.
//  - No tri-states: all outputs are driven 0 when inactive.
//  - req = ce && address[31]. stall = (IDLE && req && slot mapped && !(read && WO slot)) || ACCESS. Combinational.
//  - IDLE, req, slot mapped: latch slot, rw, address[7:4], data_from_mips -> ACCESS.
//  - IDLE, req, slot unmapped: bus_error=1 this cycle, stall=0, no strobe, stay IDLE.
//  - IDLE, req, read of WO slot: stall=0, data_to_mips=0 this cycle, no strobe, stay IDLE.
//  - ACCESS: ce_out[slot]=1; rw_out[slot]=latched rw; data_to_periph=latched wdata on a write, else 0. Counter increments each cycle.
//      periph_ready[slot]=1: capture rdata of the slot, masked per NARROW_MASK, into the read register -> DONE.
//      counter==TIMEOUT-1 with no ready (TIMEOUT!=0): -> ERROR. Ready in the same cycle wins over timeout.
//      periph_ready bits of other slots are ignored.
//  - DONE: strobes 0; stall=0; data_to_mips=captured data (0 for writes); ce ignored (CPU still holds the same request) -> IDLE.
//  - ERROR: strobes 0; stall=0; bus_error=1; data_to_mips=0 -> IDLE.
//  - Latency: minimum stall is 2 cycles (request cycle + one ACCESS cycle with ready); the CPU advances on the DONE edge.
//  - Counter clears on entry to ACCESS; width $clog2(TIMEOUT+1), min 1 bit; it never wraps because ERROR fires first.
//  - address[31]=0: all outputs stay 0, stall=0 in every state.
// STRUCTURE
//  - Package periph_bus_pkg: state encoding (IDLE, ACCESS, DONE, ERROR) and the address field constants
//    PERIPH_BIT=31, SLOT_HI=11, SLOT_LO=8, REG_HI=7, REG_LO=4.
//  - Sub-module periph_timeout_counter (clear, enable, TIMEOUT parameter, expired output).
//  - FSM and one-hot decode sit in this module. The rdata mux is indexed by the latched slot.
// TESTING
//  1 Read slot 0, ready one cycle after request, rdata0=32'h1234_5678: stall high 2 cycles, then data_to_mips=32'h1234_5678 for exactly 1 cycle.
//  2 Write 32'hCAFE_0001 to address 32'h8000_0130: ce_out=rw_out=4'b0010, address_reg=3, data_to_periph=32'hCAFE_0001 until ready.
//  3 Read narrow slot 2, rdata2=32'hAABB_CCDD: data_to_mips=32'h0000_00DD.
//  4 Access to 32'h8000_0500 (NUM_PERIPH=4): bus_error 1 cycle, stall 0, ce_out 0. Read slot 3 (WO): no strobe, data 0, stall 0.
//  5 TIMEOUT=8, slot 1 never ready: stall 9 cycles, then bus_error and data_to_mips=0 for 1 cycle, then IDLE. Ready on cycle 8 -> DONE, no error.
//  6 rst asserted on the 2nd ACCESS cycle: next cycle all outputs 0, state IDLE. A new read then completes normally.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus controller: FSM states and
// address field positions of the peripheral window.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam int PERIPH_BIT = 31;
    localparam int SLOT_HI    = 11;
    localparam int SLOT_LO    = 8;
    localparam int REG_HI     = 7;
    localparam int REG_LO     = 4;

    function automatic logic [31:0] mask_rdata(input logic [31:0] d, input logic narrow);
        return narrow ? {24'b0, d[7:0]} : d;
    endfunction

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// CPU-side and slot-side signals of the peripheral bus controller.
// The controller takes the slave modport; the CPU/peripheral side takes master.
interface periph_bus_ctrl_if #(
    parameter int NUM_PERIPH = 4
);
    logic [31:0]                  address;
    logic                         rw;
    logic                         ce;
    logic [31:0]                  data_from_mips;
    logic [NUM_PERIPH-1:0][31:0]  data_from_periph;
    logic [NUM_PERIPH-1:0]        periph_ready;
    logic [NUM_PERIPH-1:0]        ce_out;
    logic [NUM_PERIPH-1:0]        rw_out;
    logic [31:0]                  data_to_periph;
    logic [3:0]                   address_reg;
    logic [31:0]                  data_to_mips;
    logic                         stall;
    logic                         bus_error;

    modport slave (
        input  address, rw, ce, data_from_mips, data_from_periph, periph_ready,
        output ce_out, rw_out, data_to_periph, address_reg, data_to_mips, stall, bus_error
    );

    modport master (
        output address, rw, ce, data_from_mips, data_from_periph, periph_ready,
        input  ce_out, rw_out, data_to_periph, address_reg, data_to_mips, stall, bus_error
    );
endinterface

// File: rtl/periph_timeout_counter.sv
// Counts ACCESS cycles and flags the last cycle allowed before abort.
// TIMEOUT=0 disables the limit; the count holds once expired so it never wraps.
module periph_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    assign expired = (TIMEOUT != 0) && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (TIMEOUT != 0) && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/periph_bus_ctrl.sv
// Clocked bridge from the MIPS data port to up to 16 peripheral slots with
// ready handshake, CPU stall, timeout, bus error and per-slot read masking.
module periph_bus_ctrl
    import periph_bus_pkg::*;
#(
    parameter int          NUM_PERIPH  = 4,
    parameter logic [15:0] NARROW_MASK = 16'h0004,
    parameter logic [15:0] WO_MASK     = 16'h0008,
    parameter int          TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    periph_bus_ctrl_if.slave bus
);
    state_e      state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic        rw_q, rw_d;
    logic [3:0]  reg_q, reg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  slot;
    logic        req, mapped, wo_read;
    logic        rdy_sel;
    logic [31:0] rdata_sel;
    logic        cnt_clear, cnt_expired;

    logic [NUM_PERIPH-1:0] ce_o, rw_o;
    logic [31:0] dtp_o, dtm_o;
    logic [3:0]  areg_o;
    logic        stall_o, err_o;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.address[30:12], bus.address[3:0]};

    // Request decode and the slot mux, which follows the latched slot only.
    always_comb begin
        slot      = bus.address[SLOT_HI:SLOT_LO];
        req       = bus.ce && bus.address[PERIPH_BIT];
        mapped    = int'(slot) < NUM_PERIPH;
        wo_read   = !bus.rw && WO_MASK[slot];
        rdy_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (slot_q == 4'(i)) begin
                rdy_sel   = bus.periph_ready[i];
                rdata_sel = bus.data_from_periph[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        rw_d      = rw_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_clear = 1'b0;
        ce_o      = '0;
        rw_o      = '0;
        dtp_o     = '0;
        dtm_o     = '0;
        areg_o    = '0;
        stall_o   = 1'b0;
        err_o     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!mapped) begin
                        err_o = 1'b1;
                    end else if (!wo_read) begin
                        stall_o   = 1'b1;
                        slot_d    = slot;
                        rw_d      = bus.rw;
                        reg_d     = bus.address[REG_HI:REG_LO];
                        wdata_d   = bus.data_from_mips;
                        cnt_clear = 1'b1;
                        state_d   = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                stall_o = 1'b1;
                for (int i = 0; i < NUM_PERIPH; i++) begin
                    ce_o[i] = (slot_q == 4'(i));
                    rw_o[i] = (slot_q == 4'(i)) && rw_q;
                end
                dtp_o  = rw_q ? wdata_q : '0;
                areg_o = reg_q;
                // Ready takes priority over a timeout landing on the same cycle.
                if (rdy_sel) begin
                    rdata_d = rw_q ? '0 : mask_rdata(rdata_sel, NARROW_MASK[slot_q]);
                    state_d = ST_DONE;
                end else if (cnt_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE: begin
                dtm_o   = rdata_q;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                err_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            rw_q    <= 1'b0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            rw_q    <= rw_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    periph_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (state_q == ST_ACCESS),
        .expired (cnt_expired)
    );

    assign bus.ce_out         = ce_o;
    assign bus.rw_out         = rw_o;
    assign bus.data_to_periph = dtp_o;
    assign bus.address_reg    = areg_o;
    assign bus.data_to_mips   = dtm_o;
    assign bus.stall          = stall_o;
    assign bus.bus_error      = err_o;
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Bench for periph_bus_ctrl: transaction-level reference checked every cycle,
// plus directed accesses with hand-computed results.
module tb_periph_bus_ctrl;
    localparam int NP = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    periph_bus_ctrl_if #(.NUM_PERIPH(NP)) bus();

    periph_bus_ctrl #(
        .NUM_PERIPH  (NP),
        .NARROW_MASK (16'h0004),
        .WO_MASK     (16'h0008),
        .TIMEOUT     (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an outstanding transfer, how long it has waited, and a one-cycle reply.
    bit          m_busy = 0, m_rep = 0, m_rep_err = 0, m_rw = 0;
    int          m_waited = 0, m_slot = 0;
    logic [31:0] m_rep_data = '0, m_wd = '0;
    logic [3:0]  m_reg = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0;
            m_rep  <= 0;
        end else if (m_rep) begin
            m_rep <= 0;
        end else if (m_busy) begin
            if (bus.periph_ready[m_slot]) begin
                m_busy     <= 0;
                m_rep      <= 1;
                m_rep_err  <= 0;
                m_rep_data <= m_rw ? 32'h0 :
                              (m_slot == 2) ? {24'h0, bus.data_from_periph[m_slot][7:0]} :
                              bus.data_from_periph[m_slot];
            end else if (m_waited + 1 == TO) begin
                m_busy    <= 0;
                m_rep     <= 1;
                m_rep_err <= 1;
            end
            m_waited <= m_waited + 1;
        end else if (bus.ce && bus.address[31] && int'(bus.address[11:8]) < NP &&
                     !(!bus.rw && bus.address[11:8] == 4'd3)) begin
            m_busy   <= 1;
            m_waited <= 0;
            m_slot   <= int'(bus.address[11:8]);
            m_rw     <= bus.rw;
            m_reg    <= bus.address[7:4];
            m_wd     <= bus.data_from_mips;
        end
    end

    logic        e_stall, e_err;
    logic [3:0]  e_ce, e_rw, e_areg;
    logic [31:0] e_dtp, e_dtm;

    always @(negedge clk) begin
        if (chk_on) begin
            e_stall = 0; e_err = 0; e_ce = 0; e_rw = 0; e_areg = 0; e_dtp = 0; e_dtm = 0;
            if (m_rep) begin
                e_err = m_rep_err;
                e_dtm = m_rep_err ? 32'h0 : m_rep_data;
            end else if (m_busy) begin
                e_stall = 1;
                e_ce    = 4'(1 << m_slot);
                e_rw    = m_rw ? e_ce : 4'h0;
                e_dtp   = m_rw ? m_wd : 32'h0;
                e_areg  = m_reg;
            end else if (bus.ce && bus.address[31]) begin
                if (int'(bus.address[11:8]) >= NP) e_err = 1;
                else if (!(!bus.rw && bus.address[11:8] == 4'd3)) e_stall = 1;
            end
            chk("cyc_stall", 32'(bus.stall), 32'(e_stall));
            chk("cyc_bus_error", 32'(bus.bus_error), 32'(e_err));
            chk("cyc_ce_out", 32'(bus.ce_out), 32'(e_ce));
            chk("cyc_rw_out", 32'(bus.rw_out), 32'(e_rw));
            chk("cyc_data_to_periph", bus.data_to_periph, e_dtp);
            chk("cyc_address_reg", 32'(bus.address_reg), 32'(e_areg));
            chk("cyc_data_to_mips", bus.data_to_mips, e_dtm);
        end
    end

    // One CPU access; ready for the addressed slot is raised on cycle rdy_at (0 = request cycle).
    task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int rdy_at, output int nst, output logic [31:0] r_dtm,
                          output logic r_err, output logic [3:0] r_ce,
                          output logic [3:0] a_ce, output logic [3:0] a_rw,
                          output logic [3:0] a_reg, output logic [31:0] a_dtp);
        bit done = 0;
        logic [3:0] s;
        s = addr[11:8];
        nst = 0; r_dtm = 'x; r_err = 'x; r_ce = 'x;
        a_ce = 0; a_rw = 0; a_reg = 0; a_dtp = 0;
        @(posedge clk); #1;
        bus.address = addr; bus.rw = wr; bus.data_from_mips = wd; bus.ce = 1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            bus.periph_ready = (k == rdy_at) ? NP'(1 << s) : '0;
            @(negedge clk);
            if (k == 1) begin
                a_ce = bus.ce_out; a_rw = bus.rw_out; a_reg = bus.address_reg; a_dtp = bus.data_to_periph;
            end
            if (!bus.stall) begin
                r_dtm = bus.data_to_mips; r_err = bus.bus_error; r_ce = bus.ce_out;
                done = 1;
                break;
            end
            nst++;
        end
        if (!done) chk("access_cycle_bound", 32'(done), 32'd1);
        @(posedge clk); #1;
        bus.ce = 0; bus.address = 0; bus.rw = 0; bus.data_from_mips = 0; bus.periph_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          nst;
    logic [31:0] r_dtm, a_dtp;
    logic        r_err;
    logic [3:0]  r_ce, a_ce, a_rw, a_reg;

    initial begin
        bus.address = 0; bus.rw = 0; bus.ce = 0; bus.data_from_mips = 0; bus.periph_ready = 0;
        bus.data_from_periph[0] = 32'h1234_5678;
        bus.data_from_periph[1] = 32'h1111_2222;
        bus.data_from_periph[2] = 32'hAABB_CCDD;
        bus.data_from_periph[3] = 32'hDEAD_BEEF;
        rst = 1;
        @(posedge clk); #1;
        chk_on = 1;
        @(negedge clk);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_ce_out", 32'(bus.ce_out), 32'd0);
        chk("reset_data_to_mips", bus.data_to_mips, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Read slot 0, ready on the first ACCESS cycle
        access(32'h8000_0000, 0, 0, 1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t1_stall_cycles", 32'(nst), 32'd2);
        chk("t1_data", r_dtm, 32'h1234_5678);
        @(negedge clk);
        chk("t1_data_one_cycle", bus.data_to_mips, 32'h0);

        // Write slot 1, register 3, ready on second ACCESS cycle
        access(32'h8000_0130, 1, 32'hCAFE_0001, 2, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t2_ce_out", 32'(a_ce), 32'h2);
        chk("t2_rw_out", 32'(a_rw), 32'h2);
        chk("t2_address_reg", 32'(a_reg), 32'h3);
        chk("t2_wdata", a_dtp, 32'hCAFE_0001);
        chk("t2_stall_cycles", 32'(nst), 32'd3);
        chk("t2_write_reply", r_dtm, 32'h0);

        // Narrow read of slot 2
        access(32'h8000_0200, 0, 0, 1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t3_narrow_data", r_dtm, 32'h0000_00DD);

        // Unmapped slot 5
        access(32'h8000_0500, 0, 0, -1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t4_unmapped_stall", 32'(nst), 32'd0);
        chk("t4_unmapped_err", 32'(r_err), 32'd1);
        chk("t4_unmapped_ce", 32'(r_ce), 32'd0);

        // Read of write-only slot 3
        access(32'h8000_0300, 0, 0, -1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t4_wo_stall", 32'(nst), 32'd0);
        chk("t4_wo_data", r_dtm, 32'h0);
        chk("t4_wo_err", 32'(r_err), 32'd0);
        chk("t4_wo_ce", 32'(r_ce), 32'd0);

        // Write to write-only slot 3 is a normal access
        access(32'h8000_0310, 1, 32'h0000_00A5, 1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t4_wo_write_stall", 32'(nst), 32'd2);
        chk("t4_wo_write_rw", 32'(a_rw), 32'h8);

        // Data memory path: no activity
        access(32'h0000_0130, 0, 0, -1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("dmem_stall", 32'(nst), 32'd0);
        chk("dmem_err", 32'(r_err), 32'd0);

        // Timeout: slot 1 never ready
        access(32'h8000_0100, 0, 0, -1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t5_timeout_stall", 32'(nst), 32'd9);
        chk("t5_timeout_err", 32'(r_err), 32'd1);
        chk("t5_timeout_data", r_dtm, 32'h0);

        // Ready on the last allowed cycle wins
        access(32'h8000_0100, 0, 0, 8, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t5_late_stall", 32'(nst), 32'd9);
        chk("t5_late_err", 32'(r_err), 32'd0);
        chk("t5_late_data", r_dtm, 32'h1111_2222);

        // Reset during the second ACCESS cycle
        @(posedge clk); #1;
        bus.address = 32'h8000_0000; bus.rw = 0; bus.ce = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; bus.ce = 0; bus.address = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("t6_stall", 32'(bus.stall), 32'd0);
        chk("t6_ce_out", 32'(bus.ce_out), 32'd0);
        chk("t6_bus_error", 32'(bus.bus_error), 32'd0);
        chk("t6_data_to_mips", bus.data_to_mips, 32'd0);
        access(32'h8000_0000, 0, 0, 1, nst, r_dtm, r_err, r_ce, a_ce, a_rw, a_reg, a_dtp);
        chk("t6_after_stall", 32'(nst), 32'd2);
        chk("t6_after_data", r_dtm, 32'h1234_5678);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
